multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle control FSM for the 16-bit core. Sequences fetch, decode, execute, memory and writeback.
//  Drives the mux selects and write strobes of the shared ALU, memory port, register file and immediate path.
//  Decodes the 4-bit opcode taken from the IR, inst[3:0]. Handles variable-latency memory with a req/ready handshake and a timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready per access before FAULT (1..2^CNT_W-1)
//  CNT_W        4   width of the wait counter
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  opcode       in   4  IR[3:0]; sampled in DECODE and later states
//  alu_zero     in   1  ALU result==0 (valid in BRANCH)
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request, held until mem_ready
//  mem_we       out  1  write access (valid with mem_req)
//  iord         out  1  addr select: 0=PC, 1=ALUOut
//  ir_write     out  1  load IR from memory data
//  pc_write     out  1  load PC
//  pc_src       out  1  PC source: 0=ALU result, 1=ALUOut
//  alu_src_a    out  1  0=PC, 1=regA
//  alu_src_b    out  2  00=regB, 01=const 2, 10=imm_gen out
//  alu_op       out  3  000 add,001 sub,010 and,011 or,100 slt
//  reg_write    out  1  register file write enable
//  wb_src       out  2  00=ALUOut, 01=MDR, 10=imm_gen out
//  instr_done   out  1  1-cycle pulse in the final cycle of each instruction
//  fault        out  1  sticky: illegal opcode or memory timeout
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  States (encoding): FETCH=0 DECODE=1 EXEC=2 MEMADDR=3 MEMRD=4 MEMWR=5 WB=6 BRANCH=7 FAULT=8.
//  Reset: state=FETCH, wait counter=0, fault=0. All outputs read 0 while reset is high.
//   First mem_req is issued in the first cycle after reset deasserts.
//  Outputs are Moore, decoded from the state register. ir_write/pc_write in FETCH are also gated by mem_ready.
//  FETCH: mem_req=1 iord=0; alu_src_a=0 alu_src_b=01 alu_op=add. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE.
//  DECODE: alu_src_a=0 alu_src_b=10 alu_op=add (branch target into ALUOut). Next state by opcode:
//   0000-0100 R-type -> EXEC; 1000 addi -> EXEC; 1001 lw, 1010 sw -> MEMADDR; 0110 beq -> BRANCH;
//   0101 lui, 1111 li -> WB; 0111, 1011-1110 -> FAULT.
//  EXEC: alu_src_a=1. R-type: alu_src_b=00 alu_op=opcode[2:0]. addi: alu_src_b=10 alu_op=add. Next WB.
//  MEMADDR: alu_src_a=1 alu_src_b=10 alu_op=add. Next MEMRD (lw) or MEMWR (sw).
//  MEMRD/MEMWR: mem_req=1 iord=1 mem_we=(MEMWR). Wait for mem_ready.
//   MEMRD+ready -> WB. MEMWR+ready -> FETCH with instr_done=1.
//  WB: reg_write=1, instr_done=1, next FETCH. wb_src: 01 for lw, 10 for lui/li, else 00.
//  BRANCH: alu_src_a=1 alu_src_b=00 alu_op=sub. If alu_zero: pc_write=1 pc_src=1. instr_done=1, next FETCH.
//  Instruction cycle counts with zero wait states: beq/lui/li 3; R-type/addi/sw 4; lw 5.
//   Each memory wait cycle adds 1.
//  Wait counter: cleared on entry to FETCH/MEMRD/MEMWR and on every handshake.
//   Increments each cycle mem_req=1 and mem_ready=0.
//   Reaching MEM_TIMEOUT with mem_ready=0 -> FAULT. If mem_ready is high in that same cycle, ready wins (normal path).
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  FAULT: fault=1, every strobe/select 0, no exit except reset.
//  Async reset mid-access: mem_req drops immediately; the partial instruction is abandoned (no reg/PC/mem write).
// TESTING
//  1. Reset, then add (0000), mem_ready tied 1 -> states 0,1,2,6,0. reg_write only in WB; instr_done at cycle 4; alu_op=000 in EXEC.
//  2. lw (1001), mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, iord=1, mem_we=0. WB has wb_src=01; total 8 cycles.
//  3. beq (0110) with alu_zero=1, then with 0 -> pc_write=1 pc_src=1 in BRANCH only when zero; 3 cycles each.
//  4. lui (0101) and li (1111) -> FETCH,DECODE,WB with wb_src=10; no EXEC/memory cycles.
//  5. opcode 1100 -> FAULT after DECODE, fault=1 sticky across 20 cycles. Reset clears it to FETCH.
//  6. mem_ready never asserted in FETCH -> FAULT after exactly 15 wait cycles. Ready on cycle 15 instead -> DECODE.
//     Async reset mid-MEMWR -> mem_req=0 the same cycle.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM for the 16-bit core: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath selects/strobes.
// Memory accesses use a req/ready handshake guarded by a wait-cycle timeout.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_src,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWR   = 4'd5,
    S_WB      = 4'd6,
    S_BRANCH  = 4'd7,
    S_FAULT   = 4'd8
  } state_t;

  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_LI   = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] WB_ALUOUT  = 2'b00;
  localparam logic [1:0] WB_MDR     = 2'b01;
  localparam logic [1:0] WB_IMM     = 2'b10;

  // Last allowed wait count: one more unanswered cycle here is a timeout.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;

  assign w_timeout = (r_wait_cnt == LP_CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  // Wait counter: restarts on every state change (entry or handshake),
  // counts cycles where a request is outstanding and unanswered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_wait_cnt <= '0;
    else if (w_state_next != r_state)   r_wait_cnt <= '0;
    else if (mem_req && !mem_ready)     r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Next-state and Moore output decode; everything forced low during reset.
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_src       = WB_ALUOUT;
    instr_done   = 1'b0;
    fault        = 1'b0;
    state        = r_state;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_TWO;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (opcode)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
          OP_ADDI:        w_state_next = S_EXEC;
          OP_LW, OP_SW:   w_state_next = S_MEMADDR;
          OP_BEQ:         w_state_next = S_BRANCH;
          OP_LUI, OP_LI:  w_state_next = S_WB;
          default:        w_state_next = S_FAULT;
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (!opcode[3]) begin
          alu_src_b = SRCB_REG;
          alu_op    = opcode[2:0];
        end else begin
          alu_src_b = SRCB_IMM;
        end
        w_state_next = S_WB;
      end
      S_MEMADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)      w_state_next = S_WB;
        else if (w_timeout) w_state_next = S_FAULT;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done   = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_LW)                         wb_src = WB_MDR;
        else if ((opcode == OP_LUI) || (opcode == OP_LI)) wb_src = WB_IMM;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        instr_done = 1'b1;
        if (alu_zero) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        w_state_next = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        w_state_next = S_FAULT;
      end
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      wb_src     = WB_ALUOUT;
      instr_done = 1'b0;
      fault      = 1'b0;
      state      = 4'd0;
    end
  end

endmodule
